fifo_wr_ctrl: RTL and testbench
===============================

// Module: fifo_wr_ctrl
// PURPOSE
//  Write-domain controller for the 8-entry dual-port FIFO memory. It arbitrates two write
//  requesters round-robin and drives the memory write port (wen/waddr/wdata).
//  It owns the binary and Gray write pointers and synchronises the read-domain Gray pointer.
//  From these it generates full, almost_full and the occupancy count. Sits entirely in wclk.
// PARAMETERS
//  DATA_W        16  width of requester data and memory word
//  ADDR_W        3   memory address width; depth = 2**ADDR_W (8)
//  AFULL_THRESH  6   almost_full asserts when wcount >= AFULL_THRESH
//  SYNC_STAGES   2   flop stages on rptr_gray_async (min 2)
// PORTS
//  wclk             in   1         write clock
//  wrst_n           in   1         reset, asynchronous, active-low
//  req0_valid       in   1         requester 0 has a word
//  req0_data        in   DATA_W    requester 0 word
//  req0_ready       out  1         requester 0 word accepted this cycle (when valid)
//  req1_valid       in   1         requester 1 has a word
//  req1_data        in   DATA_W    requester 1 word
//  req1_ready       out  1         requester 1 word accepted this cycle (when valid)
//  rptr_gray_async  in   ADDR_W+1  read pointer, Gray, from rclk domain
//  wen              out  1         memory write enable (registered)
//  waddr            out  ADDR_W    memory write address (registered)
//  wdata            out  DATA_W    memory write data (registered)
//  wptr_gray        out  ADDR_W+1  write pointer, Gray, registered, to read domain
//  full             out  1         FIFO full (registered)
//  almost_full      out  1         wcount >= AFULL_THRESH (registered)
//  wcount           out  ADDR_W+1  occupancy as seen in write domain, 0..8
//  blocked_sticky   out  1         set if any valid seen while full
//  blocked_clr      in   1         clears blocked_sticky
// BEHAVIOUR
//  - Reset: wptr_bin=0, wptr_gray=0, all sync flops=0, wen=0, waddr=0, wdata=0, full=0,
//    almost_full=0, wcount=0, blocked_sticky=0, last_grant=1 (req0 wins first tie).
//  - Arbitration (combinational): grant only when !full. One valid -> that requester.
//    Both valid -> requester != last_grant.
//    reqN_ready = grantN. Accept = valid & ready; at most one accept per cycle.
//  - last_grant updates only on accept; an idle cycle does not move priority.
//  - On the accept edge:
//    - wen<=1, waddr<=wptr_bin[ADDR_W-1:0] (pre-increment), wdata<=granted data.
//    - wptr_bin<=wptr_bin+1 (wraps mod 2**(ADDR_W+1)); wptr_gray<=next^(next>>1).
//  - No accept: wen<=0; waddr/wdata hold. Write latency: accept edge -> wen high next cycle.
//  - Read pointer: rptr_gray_async passes through SYNC_STAGES flops -> rq_gray.
//    rq_gray is converted Gray->binary -> rq_bin.
//  - full <= (next_wgray == {~rq_gray[A:A-1], rq_gray[A-2:0]}), A=ADDR_W, using the
//    post-accept pointer, so full is set on the edge that accepts the 8th word.
//    No accept occurs while full.
//  - wcount <= next_wbin - rq_bin (ADDR_W+1 bit modular); almost_full <= (that >= AFULL_THRESH).
//  - full/wcount are pessimistic: a read frees space only after SYNC_STAGES+1 wclk edges.
//  - Pointer wrap: 16 accepts return wptr_bin to 0; each step changes exactly 1 Gray bit.
//  - blocked_sticky: set on edge where full & (req0_valid|req1_valid).
//    blocked_clr wins over set in same cycle.
//  - Reset mid-operation: all state returns to reset values asynchronously.
//    A word being accepted in that cycle is dropped.
//    Read-domain reset is coordinated at system level.
// TESTING
//  1 Reset, rptr=0, req0_valid=1 for 10 cycles -> 8 accepts, waddr 0..7 one cycle later.
//    full=1 after 8th; req0_ready=0 for cycles 9-10; blocked_sticky=1; wcount=8.
//  2 Empty FIFO, both valid continuously, data 0xA000+n / 0xB000+n ->
//    writes alternate req0,req1,req0,... starting req0; exactly one accept per cycle.
//  3 Full, then rptr_gray_async 0->1 -> full stays 1 for 2 cycles.
//    full=0 and wcount=7 on 3rd edge; next accept writes waddr=0.
//  4 Stream 20 words with rptr tracking -> wptr_gray sequence matches Gray(0..19 mod 16).
//    waddr wraps 7->0; almost_full tracks wcount>=6.
//  5 Assert wrst_n=0 mid-burst with wcount=5 -> all outputs reset immediately.
//    First post-reset accept writes waddr=0 and grants req0.
//  6 blocked_sticky=1, blocked_clr=1 while full&valid -> sticky reads 0 next cycle.

Source files
------------

// File: rtl/fifo_wr_ctrl_if.sv
// Write-side bundle of the FIFO: two requester handshakes plus the memory write port.
// master = requester/memory side, slave = fifo_wr_ctrl.
interface fifo_wr_ctrl_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3
);
  logic              req0_valid;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              wen;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready, wen, waddr, wdata
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready, wen, waddr, wdata
  );
endinterface

// File: rtl/fifo_wr_ctrl.sv
// Write-domain controller for the 8-entry dual-port FIFO: round-robin arbitration of two
// requesters, write pointers, read-pointer synchroniser, full/almost_full/occupancy.
module fifo_wr_ctrl #(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned ADDR_W       = 3,
  parameter int unsigned AFULL_THRESH = 6,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic              wclk,
  input  logic              wrst_n,
  fifo_wr_ctrl_if.slave     bus,
  input  logic [ADDR_W:0]   rptr_gray_async,
  output logic [ADDR_W:0]   wptr_gray,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   wcount,
  output logic              blocked_sticky,
  input  logic              blocked_clr
);

  typedef enum logic {
    GRANT_REQ0 = 1'b0,
    GRANT_REQ1 = 1'b1
  } grant_e;

  // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal.
  localparam logic [ADDR_W:0] FULL_MASK = {2'b11, {(ADDR_W-1){1'b0}}};
  localparam logic [ADDR_W:0] AFULL_LVL = (ADDR_W+1)'(AFULL_THRESH);

  grant_e            last_grant;
  logic [ADDR_W:0]   wptr_bin;
  logic [ADDR_W:0]   sync_q [SYNC_STAGES];
  logic [ADDR_W:0]   rq_gray;
  logic [ADDR_W:0]   rq_bin;

  logic              grant0;
  logic              grant1;
  logic              accept;
  logic [DATA_W-1:0] grant_data;
  logic [ADDR_W:0]   next_wbin;
  logic [ADDR_W:0]   next_wgray;
  logic [ADDR_W:0]   next_wcount;

  // Read-pointer synchroniser
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= rptr_gray_async;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign rq_gray = sync_q[SYNC_STAGES-1];

  always_comb begin
    rq_bin = '0;
    for (int unsigned i = 0; i <= ADDR_W; i++) begin
      rq_bin[i] = ^(rq_gray >> i);
    end
  end

  // Arbitration: on a tie the requester that did not win last time is granted.
  always_comb begin
    grant0 = !full && bus.req0_valid && (!bus.req1_valid || last_grant == GRANT_REQ1);
    grant1 = !full && bus.req1_valid && (!bus.req0_valid || last_grant == GRANT_REQ0);
    accept = grant0 || grant1;
    grant_data = grant1 ? bus.req1_data : bus.req0_data;
    bus.req0_ready = grant0;
    bus.req1_ready = grant1;
  end

  always_comb begin
    next_wbin   = wptr_bin + (ADDR_W+1)'(accept);
    next_wgray  = next_wbin ^ (next_wbin >> 1);
    next_wcount = next_wbin - rq_bin;
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      last_grant <= GRANT_REQ1;
      wptr_bin   <= '0;
      wptr_gray  <= '0;
      bus.wen    <= 1'b0;
      bus.waddr  <= '0;
      bus.wdata  <= '0;
    end else begin
      bus.wen <= accept;
      if (accept) begin
        last_grant <= grant1 ? GRANT_REQ1 : GRANT_REQ0;
        bus.waddr  <= wptr_bin[ADDR_W-1:0];
        bus.wdata  <= grant_data;
      end
      wptr_bin  <= next_wbin;
      wptr_gray <= next_wgray;
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      full        <= 1'b0;
      almost_full <= 1'b0;
      wcount      <= '0;
    end else begin
      full        <= (next_wgray == (rq_gray ^ FULL_MASK));
      almost_full <= (next_wcount >= AFULL_LVL);
      wcount      <= next_wcount;
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      blocked_sticky <= 1'b0;
    end else if (blocked_clr) begin
      blocked_sticky <= 1'b0;
    end else if (full && (bus.req0_valid || bus.req1_valid)) begin
      blocked_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl: fill/full, round-robin, read release, pointer wrap,
// mid-burst reset and blocked_sticky clear priority.
module tb_fifo_wr_ctrl;

    logic       wclk = 1'b0;
    logic       wrst_n = 1'b0;
    logic [3:0] rptr_gray_async = '0;
    logic [3:0] wptr_gray;
    logic       full;
    logic       almost_full;
    logic [3:0] wcount;
    logic       blocked_sticky;
    logic       blocked_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    fifo_wr_ctrl_if #(.DATA_W(16), .ADDR_W(3)) bus ();

    fifo_wr_ctrl #(
        .DATA_W(16),
        .ADDR_W(3),
        .AFULL_THRESH(6),
        .SYNC_STAGES(2)
    ) dut (
        .wclk(wclk),
        .wrst_n(wrst_n),
        .bus(bus.slave),
        .rptr_gray_async(rptr_gray_async),
        .wptr_gray(wptr_gray),
        .full(full),
        .almost_full(almost_full),
        .wcount(wcount),
        .blocked_sticky(blocked_sticky),
        .blocked_clr(blocked_clr)
    );

    always #5 wclk = ~wclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] gray(input int x);
        logic [3:0] b;
        b = 4'(x);
        return b ^ (b >> 1);
    endfunction

    task automatic idle_inputs();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_data  = '0;
        bus.req1_data  = '0;
        blocked_clr    = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rptr_gray_async = '0;
        wrst_n = 1'b0;
        @(posedge wclk);
        #1;
        wrst_n = 1'b1;
    endtask

    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_wen"},   32'(bus.wen), 32'd0);
        check({tag, "_waddr"}, 32'(bus.waddr), 32'd0);
        check({tag, "_wdata"}, 32'(bus.wdata), 32'd0);
        check({tag, "_wgray"}, 32'(wptr_gray), 32'd0);
        check({tag, "_full"},  32'(full), 32'd0);
        check({tag, "_afull"}, 32'(almost_full), 32'd0);
        check({tag, "_wcount"}, 32'(wcount), 32'd0);
        check({tag, "_sticky"}, 32'(blocked_sticky), 32'd0);
    endtask

    initial begin
        idle_inputs();
        #2;
        check_reset_state("rst");

        // Single requester, 10 cycles into an 8-deep FIFO with no reads
        do_reset();
        for (int c = 0; c < 10; c++) begin
            bus.req0_valid = 1'b1;
            bus.req0_data  = 16'(16'h1000 + c);
            #1;
            check("t1_ready", 32'(bus.req0_ready), 32'(c < 8));
            step();
            check("t1_wen", 32'(bus.wen), 32'(c < 8));
            if (c < 8) begin
                check("t1_waddr", 32'(bus.waddr), 32'(c));
                check("t1_wdata", 32'(bus.wdata), 32'(16'h1000 + c));
            end
            check("t1_full",   32'(full), 32'(c >= 7));
            check("t1_wcount", 32'(wcount), 32'((c < 8) ? c + 1 : 8));
            check("t1_afull",  32'(almost_full), 32'(c >= 5));
        end
        check("t1_sticky", 32'(blocked_sticky), 32'd1);

        // Both requesters continuously valid: alternate starting with req0
        do_reset();
        for (int c = 0; c < 8; c++) begin
            bus.req0_valid = 1'b1;
            bus.req1_valid = 1'b1;
            bus.req0_data  = 16'(16'hA000 + c);
            bus.req1_data  = 16'(16'hB000 + c);
            #1;
            check("t2_ready0", 32'(bus.req0_ready), 32'(c % 2 == 0));
            check("t2_ready1", 32'(bus.req1_ready), 32'(c % 2 == 1));
            step();
            check("t2_wen",   32'(bus.wen), 32'd1);
            check("t2_waddr", 32'(bus.waddr), 32'(c));
            check("t2_wdata", 32'(bus.wdata), 32'((c % 2 == 0) ? 16'hA000 + c : 16'hB000 + c));
        end
        check("t2_full", 32'(full), 32'd1);

        // Read one word: full clears only on the third edge after the pointer moves
        idle_inputs();
        rptr_gray_async = 4'b0001;
        step();
        check("t3_full_e1", 32'(full), 32'd1);
        step();
        check("t3_full_e2", 32'(full), 32'd1);
        step();
        check("t3_full_e3", 32'(full), 32'd0);
        check("t3_wcount", 32'(wcount), 32'd7);
        check("t3_afull",  32'(almost_full), 32'd1);
        check("t3_sticky", 32'(blocked_sticky), 32'd0);
        bus.req0_valid = 1'b1;
        bus.req0_data  = 16'h3333;
        #1;
        check("t3_ready0", 32'(bus.req0_ready), 32'd1);
        step();
        check("t3_wen",    32'(bus.wen), 32'd1);
        check("t3_waddr",  32'(bus.waddr), 32'd0);
        check("t3_wdata",  32'(bus.wdata), 32'h3333);
        check("t3_refull", 32'(full), 32'd1);
        check("t3_wcnt8",  32'(wcount), 32'd8);

        // Stream 20 words, reader trailing four words behind
        do_reset();
        for (int c = 0; c < 20; c++) begin
            bus.req0_valid  = 1'b1;
            bus.req0_data   = 16'(16'h4000 + c);
            rptr_gray_async = gray((c > 4) ? c - 4 : 0);
            step();
            check("t4_wen",    32'(bus.wen), 32'd1);
            check("t4_waddr",  32'(bus.waddr), 32'(c % 8));
            check("t4_wgray",  32'(wptr_gray), 32'(gray((c + 1) % 16)));
            check("t4_wcount", 32'(wcount), 32'((c <= 6) ? c + 1 : 7));
            check("t4_afull",  32'(almost_full), 32'(c >= 5));
            check("t4_full",   32'(full), 32'd0);
        end

        // Asynchronous reset in the middle of a burst
        do_reset();
        for (int c = 0; c < 5; c++) begin
            bus.req0_valid = 1'b1;
            bus.req0_data  = 16'(16'h5000 + c);
            step();
        end
        check("t5_wcount_pre", 32'(wcount), 32'd5);
        bus.req1_valid = 1'b1;
        bus.req0_data  = 16'hC0DE;
        bus.req1_data  = 16'hBEEF;
        wrst_n = 1'b0;
        #1;
        check_reset_state("t5");
        check("t5_ready0", 32'(bus.req0_ready), 32'd1);
        check("t5_ready1", 32'(bus.req1_ready), 32'd0);
        #1;
        wrst_n = 1'b1;
        step();
        check("t5_wen",    32'(bus.wen), 32'd1);
        check("t5_waddr",  32'(bus.waddr), 32'd0);
        check("t5_wdata",  32'(bus.wdata), 32'hC0DE);
        check("t5_wgray",  32'(wptr_gray), 32'd1);
        check("t5_wcount", 32'(wcount), 32'd1);

        // blocked_sticky set/clear priority
        do_reset();
        bus.req0_valid = 1'b1;
        bus.req0_data  = 16'h6000;
        repeat (8) step();
        check("t6_full",    32'(full), 32'd1);
        check("t6_sticky0", 32'(blocked_sticky), 32'd0);
        step();
        check("t6_set",     32'(blocked_sticky), 32'd1);
        check("t6_ready0",  32'(bus.req0_ready), 32'd0);
        blocked_clr = 1'b1;
        step();
        check("t6_clr_wins", 32'(blocked_sticky), 32'd0);
        blocked_clr = 1'b0;
        step();
        check("t6_reset",   32'(blocked_sticky), 32'd1);
        bus.req0_valid = 1'b0;
        blocked_clr = 1'b1;
        step();
        check("t6_clr",     32'(blocked_sticky), 32'd0);
        blocked_clr = 1'b0;
        step();
        check("t6_hold",    32'(blocked_sticky), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
